uart_tx_fifo_param: RTL

//  Parametrised UART transmitter: next generation of the board-level TX path.

---
 rtl/uart_tx_fifo_param.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param_fifo: generic DEPTH-entry synchronous FIFO with registered occupancy count.
// Latency: a pushed word is visible at rd_dat from the edge after the push.
// Backpressure: wr_rdy = !full from the registered count; push and pop in one cycle leave the count unchanged.
module uart_tx_fifo_param_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fire;

  assign wr_rdy = (count_q != CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign rd_dat = mem_q[rptr_q];
  assign fire   = wr_vld & wr_rdy;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (fire) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({fire, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (fire) mem_q[wptr_q] <= wr_dat;
  end
endmodule

// uart_tx_fifo_param: DEPTH-entry FIFO feeding a UART serialiser with runtime bit order, parity, stop bits and idle gap.
// Latency: a word pushed into an empty FIFO while idle is popped on the next edge; tx is low (start bit) from that edge.
// Backpressure: din_ready = FIFO not full; the serialiser drains one word per frame, config latched at pop.
module uart_tx_fifo_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 4,
  parameter int GAP_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              msb_first,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  input  logic [GAP_W-1:0]  gap_bits,
  output logic              tx,
  output logic              busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              msb_q, msb_d, pen_q, pen_d, par_q, par_d, two_q, two_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              tx_q, tx_d, busy_q, busy_d;
  logic              pop, fifo_empty, bit_end;
  logic [DATA_W-1:0] fifo_dat;

  uart_tx_fifo_param_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .wr_vld (din_valid),
    .wr_dat (din),
    .wr_rdy (din_ready),
    .pop    (pop),
    .rd_dat (fifo_dat),
    .empty  (fifo_empty)
  );

  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign tx      = tx_q;
  assign busy    = busy_q;

  // Frame sequencer: picks the next state, advances counters, and computes the line level for the state entered.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shreg_d   = shreg_q;
    msb_d     = msb_q;
    pen_d     = pen_q;
    par_d     = par_q;
    two_d     = two_q;
    gap_d     = gap_q;
    pop       = 1'b0;
    if (state_q != ST_IDLE) timer_d = bit_end ? '0 : timer_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = fifo_dat;
          msb_d     = msb_first;
          pen_d     = parity_en;
          par_d     = parity_odd ? ~^fifo_dat : ^fifo_dat;
          two_d     = two_stop;
          gap_d     = gap_bits;
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          // The outgoing bit always sits at the end selected by the latched order.
          shreg_d = msb_q ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = pen_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == BW'(two_q)) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = (gap_q != '0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (gap_cnt_q == gap_q - 1'b1) begin
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = msb_d ? shreg_d[DATA_W-1] : shreg_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE) | ~fifo_empty;
  end

  // Sequencer, config latch and output registers; reset forces the line idle-high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shreg_q   <= '0;
      msb_q     <= 1'b0;
      pen_q     <= 1'b0;
      par_q     <= 1'b0;
      two_q     <= 1'b0;
      gap_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      shreg_q   <= shreg_d;
      msb_q     <= msb_d;
      pen_q     <= pen_d;
      par_q     <= par_d;
      two_q     <= two_d;
      gap_q     <= gap_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end
endmodule
